// File: rtl/dtree_engine_if.sv
// Handshake and configuration bundle between the feature/tree loader and dtree_engine.
interface dtree_engine_if #(
    parameter int DATA_W  = 8,
    parameter int FEAT_AW = 3,
    parameter int NODE_AW = 8,
    parameter int CLASS_W = 8
);
    localparam int NW = 1 + FEAT_AW + DATA_W + 2 * NODE_AW + CLASS_W;

    logic               cfg_we;
    logic [NODE_AW-1:0] cfg_addr;
    logic [NW-1:0]      cfg_wdata;
    logic               feat_we;
    logic [FEAT_AW-1:0] feat_addr;
    logic [DATA_W-1:0]  feat_wdata;
    logic               start_i;
    logic               busy_o;
    logic [CLASS_W-1:0] y_o;
    logic               y_valid_o;
    logic [7:0]         depth_o;
    logic               err_o;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, feat_we, feat_addr, feat_wdata, start_i,
        input  busy_o, y_o, y_valid_o, depth_o, err_o
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, feat_we, feat_addr, feat_wdata, start_i,
        output busy_o, y_o, y_valid_o, depth_o, err_o
    );
endinterface

// File: rtl/dtree_engine.sv
// Decision-tree walker: one node per cycle from a writable node memory, class reported at the leaf.
// IDLE | memories writable, waiting for start    WALK | evaluating node_ptr, memories frozen
module dtree_engine #(
    parameter int DATA_W     = 8,
    parameter int FEAT_AW    = 3,
    parameter int FEAT_N     = 8,
    parameter int NODE_AW    = 8,
    parameter int CLASS_W    = 8,
    parameter int MAX_DEPTH  = 16,
    parameter int SIGNED_CMP = 0,
    parameter int ROOT       = 0
) (
    input logic          clk,
    input logic          reset,
    dtree_engine_if.slave bus
);
    localparam int NW       = 1 + FEAT_AW + DATA_W + 2 * NODE_AW + CLASS_W;
    localparam int CF_LSB   = CLASS_W;
    localparam int CT_LSB   = CF_LSB + NODE_AW;
    localparam int THR_LSB  = CT_LSB + NODE_AW;
    localparam int FI_LSB   = THR_LSB + DATA_W;
    localparam logic [FEAT_AW:0] FEAT_LIM   = (FEAT_AW + 1)'(FEAT_N);
    localparam logic [7:0]       DEPTH_LAST = 8'(MAX_DEPTH - 1);
    localparam logic [NODE_AW-1:0] ROOT_A   = NODE_AW'(ROOT);

    typedef enum logic {IDLE, WALK} state_t;

    state_t             state, state_nx;
    logic [NW-1:0]      node_mem [2**NODE_AW];
    logic [DATA_W-1:0]  feat_mem [2**FEAT_AW];
    logic [NODE_AW-1:0] node_ptr, node_nx;
    logic [7:0]         depth_cnt, depth_nx;
    logic [CLASS_W-1:0] y_q;
    logic [7:0]         depth_q;
    logic               y_valid_q, err_q;
    logic               load_y, y_valid_nx, err_nx;

    logic [NW-1:0]      word;
    logic               leaf;
    logic [FEAT_AW-1:0] fi;
    logic [DATA_W-1:0]  thr, feat_val;
    logic [NODE_AW-1:0] child_t, child_f;
    logic [CLASS_W-1:0] cls;
    logic               take_t;
    logic               busy;

    assign busy     = (state == WALK);
    assign word     = node_mem[node_ptr];
    assign leaf     = word[NW-1];
    assign fi       = word[FI_LSB +: FEAT_AW];
    assign thr      = word[THR_LSB +: DATA_W];
    assign child_t  = word[CT_LSB +: NODE_AW];
    assign child_f  = word[CF_LSB +: NODE_AW];
    assign cls      = word[CLASS_W-1:0];
    assign feat_val = feat_mem[fi];

    generate
        if (SIGNED_CMP != 0) begin : g_scmp
            assign take_t = $signed(feat_val) > $signed(thr);
        end else begin : g_ucmp
            assign take_t = feat_val > thr;
        end
    endgenerate

    // Memories are deliberately not reset; they only accept writes while idle.
    always_ff @(posedge clk) begin
        if (!busy && bus.cfg_we)
            node_mem[bus.cfg_addr] <= bus.cfg_wdata;
        if (!busy && bus.feat_we)
            feat_mem[bus.feat_addr] <= bus.feat_wdata;
    end

    always_comb begin
        state_nx   = state;
        node_nx    = node_ptr;
        depth_nx   = depth_cnt;
        load_y     = 1'b0;
        y_valid_nx = 1'b0;
        err_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    state_nx = WALK;
                    node_nx  = ROOT_A;
                    depth_nx = 8'd0;
                end
            end
            WALK: begin
                if (leaf) begin
                    load_y     = 1'b1;
                    y_valid_nx = 1'b1;
                    state_nx   = IDLE;
                end else if ({1'b0, fi} >= FEAT_LIM) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else if (depth_cnt == DEPTH_LAST) begin
                    // Depth limit also terminates walks around cyclic trees.
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    node_nx  = take_t ? child_t : child_f;
                    depth_nx = depth_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            node_ptr  <= ROOT_A;
            depth_cnt <= 8'd0;
            y_q       <= '0;
            depth_q   <= 8'd0;
            y_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            node_ptr  <= node_nx;
            depth_cnt <= depth_nx;
            y_valid_q <= y_valid_nx;
            err_q     <= err_nx;
            if (load_y) begin
                y_q     <= cls;
                depth_q <= depth_cnt;
            end
        end
    end

    assign bus.busy_o    = busy;
    assign bus.y_o       = y_q;
    assign bus.y_valid_o = y_valid_q;
    assign bus.depth_o   = depth_q;
    assign bus.err_o     = err_q;
endmodule
